// File: rtl/obi_pkg.sv
// Minimal OBI type definitions: configuration record plus the default
// request/response channel structs used by the user-domain subordinates.
package obi_pkg;

   typedef struct packed {
      int unsigned AddrWidth;
      int unsigned DataWidth;
      int unsigned IdWidth;
   } obi_cfg_t;

   localparam obi_cfg_t ObiDefaultConfig = '{AddrWidth: 32, DataWidth: 32, IdWidth: 4};

   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [3:0]  aid;
   } obi_a_chan_t;

   typedef struct packed {
      obi_a_chan_t a;
      logic        req;
   } obi_req_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic [3:0]  rid;
      logic        err;
   } obi_r_chan_t;

   typedef struct packed {
      obi_r_chan_t r;
      logic        gnt;
      logic        rvalid;
   } obi_rsp_t;

endpackage

// File: rtl/user_result_fifo_pkg.sv
// Register map and bit positions for the user-domain result FIFO subordinate.
package user_result_fifo_pkg;

   // word index taken from addr[3:2]
   typedef enum logic [1:0] {
      REG_DATA   = 2'd0,
      REG_STATUS = 2'd1,
      REG_CTRL   = 2'd2,
      REG_THRESH = 2'd3
   } reg_sel_e;

   localparam logic [3:0] OFF_DATA   = 4'h0;
   localparam logic [3:0] OFF_STATUS = 4'h4;
   localparam logic [3:0] OFF_CTRL   = 4'h8;
   localparam logic [3:0] OFF_THRESH = 4'hC;

   localparam int unsigned STATUS_EMPTY = 16;
   localparam int unsigned STATUS_FULL  = 17;
   localparam int unsigned STATUS_OVF   = 18;
   localparam int unsigned STATUS_UNF   = 19;

   localparam int unsigned CTRL_FLUSH = 0;
   localparam int unsigned CTRL_CLR   = 1;

endpackage

// File: rtl/user_result_fifo.sv
// Result FIFO storage: circular buffer with free-running pointers and an
// explicit occupancy count. Push/pop qualification is done by the caller;
// flush empties the buffer and overrides any same-cycle push or pop.
module user_result_fifo #(
   parameter int unsigned Depth = 8,
   parameter int unsigned Width = 32,
   localparam int unsigned PtrW = $clog2(Depth),
   localparam int unsigned CntW = $clog2(Depth) + 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [Width-1:0] data_i,
   input  logic             pop_i,
   input  logic             flush_i,
   output logic [Width-1:0] head_o,
   output logic [CntW-1:0]  count_o,
   output logic             full_o,
   output logic             empty_o
);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;

   // next pointers and occupancy; pointers wrap naturally at Depth
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_i) wr_ptr_d = wr_ptr_q + PtrW'(1);
         if (pop_i)  rd_ptr_d = rd_ptr_q + PtrW'(1);
         if (push_i && !pop_i)      count_d = count_q + CntW'(1);
         else if (!push_i && pop_i) count_d = count_q - CntW'(1);
      end
   end

   // pointer and count registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // storage write; contents are only observed through a valid head
   always_ff @(posedge clk_i) begin
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign full_o  = (count_q == CntW'(Depth));
   assign empty_o = (count_q == '0);

endmodule

// File: rtl/user_obi_result_fifo_sbr.sv
// OBI subordinate that buffers valid-only compute results and lets the CPU
// drain them through DATA and monitor them through STATUS. Grant is
// combinational, the response follows one cycle later.
// Optional: define USER_RESULT_FIFO_IRQ_EN to add the THRESH register at 0xC
// and the irq_o output.
module user_obi_result_fifo_sbr
   import user_result_fifo_pkg::*;
#(
   parameter obi_pkg::obi_cfg_t ObiCfg = obi_pkg::ObiDefaultConfig,
   parameter type obi_req_t = obi_pkg::obi_req_t,
   parameter type obi_rsp_t = obi_pkg::obi_rsp_t,
   parameter int unsigned Depth = 8
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  obi_req_t                    obi_req_i,
   output obi_rsp_t                    obi_rsp_o,
   input  logic [ObiCfg.DataWidth-1:0] result_i,
   input  logic                        result_valid_i,
   output logic                        fifo_full_o
`ifdef USER_RESULT_FIFO_IRQ_EN
   ,
   output logic                        irq_o
`endif
);

   localparam int unsigned DW   = ObiCfg.DataWidth;
   localparam int unsigned IW   = ObiCfg.IdWidth;
   localparam int unsigned CntW = $clog2(Depth) + 1;

   logic            hs, is_wr, ctrl_wr, data_rd;
   reg_sel_e        sel;
   logic [CntW-1:0] count;
   logic [DW-1:0]   head, status;
   logic            full, empty;
   logic            pop, push, flush, clr, ovf_set, unf_set;
   logic            ovf_q, ovf_d, unf_q, unf_d;
   logic            rvalid_q, rvalid_d, err_q, err_d;
   logic [DW-1:0]   rdata_q, rdata_d;
   logic [IW-1:0]   rid_q, rid_d;
   logic            unused_req;

   assign hs         = obi_req_i.req;
   assign is_wr      = obi_req_i.a.we;
   assign sel        = reg_sel_e'(obi_req_i.a.addr[3:2]);
   assign unused_req = ^obi_req_i;

   user_result_fifo #(
      .Depth (Depth),
      .Width (DW)
   ) i_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (push),
      .data_i  (result_i),
      .pop_i   (pop),
      .flush_i (flush),
      .head_o  (head),
      .count_o (count),
      .full_o  (full),
      .empty_o (empty)
   );

   // side effects of the granted request and of the result stream
   always_comb begin
      ctrl_wr = hs && is_wr && (sel == REG_CTRL) && obi_req_i.a.be[0];
      flush   = ctrl_wr && obi_req_i.a.wdata[CTRL_FLUSH];
      clr     = ctrl_wr && obi_req_i.a.wdata[CTRL_CLR];
      data_rd = hs && !is_wr && (sel == REG_DATA);
      pop     = data_rd && !empty;
      unf_set = data_rd && empty;
      // a pop in the same cycle frees the slot a full FIFO needs;
      // a flush silently discards the incoming result
      push    = result_valid_i && !flush && (!full || pop);
      ovf_set = result_valid_i && !flush && full && !pop;
      // a new event wins over a same-cycle clear
      ovf_d   = ovf_set || (ovf_q && !clr);
      unf_d   = unf_set || (unf_q && !clr);
   end

   // STATUS word assembled from the current state
   always_comb begin
      status               = '0;
      status[CntW-1:0]     = count;
      status[STATUS_EMPTY] = empty;
      status[STATUS_FULL]  = full;
      status[STATUS_OVF]   = ovf_q;
      status[STATUS_UNF]   = unf_q;
   end

`ifdef USER_RESULT_FIFO_IRQ_EN
   logic [CntW-1:0] thresh_q, thresh_d;
   logic            irq_q, irq_d;

   // threshold register and level/overflow interrupt
   always_comb begin
      thresh_d = thresh_q;
      if (hs && is_wr && (sel == REG_THRESH) && obi_req_i.a.be[0]) begin
         thresh_d = obi_req_i.a.wdata[CntW-1:0];
      end
      irq_d = (count >= thresh_q) || ovf_q;
   end

   // interrupt state registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         thresh_q <= CntW'(Depth);
         irq_q    <= 1'b0;
      end else begin
         thresh_q <= thresh_d;
         irq_q    <= irq_d;
      end
   end

   assign irq_o = irq_q;
`endif

   // response payload for the request granted this cycle
   always_comb begin
      rvalid_d = hs;
      rid_d    = hs ? obi_req_i.a.aid : rid_q;
      rdata_d  = '0;
      err_d    = 1'b0;
      if (hs) begin
         if (is_wr) begin
            err_d = (sel == REG_DATA) || (sel == REG_STATUS);
         end else begin
            case (sel)
               REG_DATA:   rdata_d = empty ? '0 : head;
               REG_STATUS: rdata_d = status;
`ifdef USER_RESULT_FIFO_IRQ_EN
               REG_THRESH: rdata_d = DW'(thresh_q);
`endif
               default:    rdata_d = '0;
            endcase
         end
      end
   end

   // sticky flags and registered response
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
         rvalid_q <= 1'b0;
         rid_q    <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
         rvalid_q <= rvalid_d;
         rid_q    <= rid_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

   // drive the response struct; no wait states
   always_comb begin
      obi_rsp_o         = '0;
      obi_rsp_o.gnt     = obi_req_i.req;
      obi_rsp_o.rvalid  = rvalid_q;
      obi_rsp_o.r.rdata = rdata_q;
      obi_rsp_o.r.rid   = rid_q;
      obi_rsp_o.r.err   = err_q;
   end

   assign fifo_full_o = full;

endmodule

// File: tb/tb_user_obi_result_fifo_sbr.sv
// Scoreboard bench for the OBI result FIFO subordinate. Expected responses
// are queued when a request is driven; a monitor queues observed responses.
module tb_user_obi_result_fifo_sbr;

   localparam int Depth = 8;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
      logic [3:0]  rid;
      int unsigned cyc;
   } rsp_rec_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   obi_pkg::obi_req_t req;
   obi_pkg::obi_rsp_t rsp;
   logic [31:0]       result;
   logic              result_valid;
   logic              fifo_full;
`ifdef USER_RESULT_FIFO_IRQ_EN
   logic              irq;
`endif

   int unsigned cyc = 0;
   int          n_cmp = 0;
   int          n_mis = 0;
   rsp_rec_t    exp_q[$];
   rsp_rec_t    act_q[$];
   logic [31:0] mdl_q[$];
   bit          ovf_m = 1'b0;
   bit          unf_m = 1'b0;
   logic [3:0]  thresh_m = 4'd8;

   user_obi_result_fifo_sbr #(.Depth(Depth)) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .obi_req_i      (req),
      .obi_rsp_o      (rsp),
      .result_i       (result),
      .result_valid_i (result_valid),
      .fifo_full_o    (fifo_full)
`ifdef USER_RESULT_FIFO_IRQ_EN
      ,
      .irq_o          (irq)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rsp.rvalid === 1'b1) act_q.push_back('{rsp.r.rdata, rsp.r.err, rsp.r.rid, cyc});
   end

   function automatic logic [31:0] status_m();
      logic [31:0] s;
      s      = '0;
      s[3:0] = 4'(mdl_q.size());
      s[16]  = (mdl_q.size() == 0);
      s[17]  = (mdl_q.size() == Depth);
      s[18]  = ovf_m;
      s[19]  = unf_m;
      return s;
   endfunction

   // drive one clock cycle of stimulus and advance the reference model
   task automatic cycle(input bit do_req, input bit we, input logic [3:0] off,
                        input logic [31:0] wdata, input logic [3:0] be, input logic [3:0] aid,
                        input bit do_push, input logic [31:0] pdata);
      rsp_rec_t e;
      bit popped, flush, clr, ovf_set, unf_set;
      popped = 0; flush = 0; clr = 0; ovf_set = 0; unf_set = 0;
      @(posedge clk); #1;
      req.req      = do_req;
      req.a.we     = we;
      req.a.addr   = {28'd0, off};
      req.a.wdata  = wdata;
      req.a.be     = be;
      req.a.aid    = aid;
      result_valid = do_push;
      result       = pdata;
      if (do_req) begin
         e.rdata = '0; e.err = 1'b0; e.rid = aid; e.cyc = cyc + 1;
         if (!we) begin
            case (off[3:2])
               2'd0: if (mdl_q.size() > 0) begin e.rdata = mdl_q[0]; popped = 1; end
                     else unf_set = 1;
               2'd1: e.rdata = status_m();
`ifdef USER_RESULT_FIFO_IRQ_EN
               2'd3: e.rdata = {28'd0, thresh_m};
`endif
               default: e.rdata = '0;
            endcase
         end else begin
            case (off[3:2])
               2'd0, 2'd1: e.err = 1'b1;
               2'd2: if (be[0]) begin flush = wdata[0]; clr = wdata[1]; end
`ifdef USER_RESULT_FIFO_IRQ_EN
               2'd3: if (be[0]) thresh_m = wdata[3:0];
`endif
               default: ;
            endcase
         end
         exp_q.push_back(e);
      end
      if (popped) mdl_q.pop_front();
      if (flush) mdl_q.delete();
      if (do_push && !flush) begin
         if (mdl_q.size() < Depth) mdl_q.push_back(pdata);
         else ovf_set = 1;
      end
      ovf_m = ovf_set | (ovf_m & ~clr);
      unf_m = unf_set | (unf_m & ~clr);
   endtask

   task automatic rd(input logic [3:0] off, input logic [3:0] aid);
      cycle(1, 0, off, 32'd0, 4'hF, aid, 0, 32'd0);
   endtask

   task automatic wr(input logic [3:0] off, input logic [31:0] d, input logic [3:0] be);
      cycle(1, 1, off, d, be, 4'd0, 0, 32'd0);
   endtask

   task automatic push(input logic [31:0] d);
      cycle(0, 0, 4'd0, 32'd0, 4'd0, 4'd0, 1, d);
   endtask

   task automatic idle();
      cycle(0, 0, 4'd0, 32'd0, 4'd0, 4'd0, 0, 32'd0);
   endtask

   // quiesce the bus and give outstanding responses a bounded time to arrive
   task automatic wait_rsp();
      idle();
      for (int i = 0; i < 20; i++) begin
         if (act_q.size() >= exp_q.size()) break;
         @(negedge clk);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      rsp_rec_t e, a;
      req = '0; result = '0; result_valid = 1'b0; rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++; if (rsp.rvalid !== 1'b0) begin n_mis++; $display("FAIL reset_rvalid got %b expected 0", rsp.rvalid); end
      n_cmp++; if (rsp.r.rdata !== 32'd0) begin n_mis++; $display("FAIL reset_rdata got %h expected 0", rsp.r.rdata); end
      n_cmp++; if (rsp.r.err !== 1'b0) begin n_mis++; $display("FAIL reset_err got %b expected 0", rsp.r.err); end
      n_cmp++; if (fifo_full !== 1'b0) begin n_mis++; $display("FAIL reset_full got %b expected 0", fifo_full); end
      rst_n = 1'b1;
      rd(4'h4, 4'd0);
      wait_rsp();
      n_cmp++; if (act_q.size() != exp_q.size()) begin n_mis++; $display("FAIL reset_rsp_count got %0d expected %0d", act_q.size(), exp_q.size()); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = (act_q.size() > 0) ? act_q.pop_front() : '0;
         n_cmp++;
         if (a !== e) begin n_mis++; $display("FAIL reset_rsp got rdata=%h err=%b rid=%0d cyc=%0d expected rdata=%h err=%b rid=%0d cyc=%0d", a.rdata, a.err, a.rid, a.cyc, e.rdata, e.err, e.rid, e.cyc); end
      end
      act_q.delete();
   endtask

   task automatic test_basic_and_underflow();
      rsp_rec_t e, a;
      push(32'h1122_3344);
      push(32'h5566_7788);
      rd(4'h0, 4'd1);
      rd(4'h0, 4'd2);
      rd(4'h4, 4'd3);
      rd(4'h0, 4'd4);
      rd(4'h4, 4'd5);
      wr(4'h8, 32'h2, 4'h1);
      rd(4'h4, 4'd6);
      wait_rsp();
      n_cmp++; if (act_q.size() != exp_q.size()) begin n_mis++; $display("FAIL basic_rsp_count got %0d expected %0d", act_q.size(), exp_q.size()); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = (act_q.size() > 0) ? act_q.pop_front() : '0;
         n_cmp++;
         if (a !== e) begin n_mis++; $display("FAIL basic_rsp got rdata=%h err=%b rid=%0d cyc=%0d expected rdata=%h err=%b rid=%0d cyc=%0d", a.rdata, a.err, a.rid, a.cyc, e.rdata, e.err, e.rid, e.cyc); end
      end
      act_q.delete();
   endtask

   task automatic test_overflow();
      rsp_rec_t e, a;
      for (int i = 0; i < Depth + 2; i++) push(32'hA000_0000 + 32'(i));
      idle();
      @(negedge clk);
      n_cmp++; if (fifo_full !== 1'b1) begin n_mis++; $display("FAIL ovf_full_pin got %b expected 1", fifo_full); end
      rd(4'h4, 4'd7);
      for (int i = 0; i < Depth; i++) rd(4'h0, 4'(i));
      for (int i = 0; i < Depth; i++) push(32'hB000_0000 + 32'(i));
      cycle(1, 0, 4'h0, 32'd0, 4'hF, 4'd9, 1, 32'hCAFE_F00D);
      rd(4'h4, 4'd10);
      for (int i = 0; i < Depth; i++) rd(4'h0, 4'(i));
      wait_rsp();
      n_cmp++; if (act_q.size() != exp_q.size()) begin n_mis++; $display("FAIL ovf_rsp_count got %0d expected %0d", act_q.size(), exp_q.size()); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = (act_q.size() > 0) ? act_q.pop_front() : '0;
         n_cmp++;
         if (a !== e) begin n_mis++; $display("FAIL ovf_rsp got rdata=%h err=%b rid=%0d cyc=%0d expected rdata=%h err=%b rid=%0d cyc=%0d", a.rdata, a.err, a.rid, a.cyc, e.rdata, e.err, e.rid, e.cyc); end
      end
      act_q.delete();
   endtask

   task automatic test_err_flush();
      rsp_rec_t e, a;
      wr(4'h8, 32'h2, 4'h1);
      for (int i = 0; i < 5; i++) push(32'hC000_0000 + 32'(i));
      wr(4'h0, 32'hDEAD_BEEF, 4'hF);
      wr(4'h4, 32'hFFFF_FFFF, 4'hF);
      rd(4'h4, 4'd1);
      wr(4'h8, 32'h1, 4'h2);
      rd(4'h4, 4'd2);
      cycle(1, 1, 4'h8, 32'h1, 4'h1, 4'd3, 1, 32'h5A5A_5A5A);
      rd(4'h4, 4'd4);
      rd(4'hC, 4'd5);
      wr(4'hC, 32'h3, 4'hF);
      wr(4'hC, 32'h8, 4'hF);
      wait_rsp();
      n_cmp++; if (act_q.size() != exp_q.size()) begin n_mis++; $display("FAIL errfl_rsp_count got %0d expected %0d", act_q.size(), exp_q.size()); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = (act_q.size() > 0) ? act_q.pop_front() : '0;
         n_cmp++;
         if (a !== e) begin n_mis++; $display("FAIL errfl_rsp got rdata=%h err=%b rid=%0d cyc=%0d expected rdata=%h err=%b rid=%0d cyc=%0d", a.rdata, a.err, a.rid, a.cyc, e.rdata, e.err, e.rid, e.cyc); end
      end
      act_q.delete();
   endtask

   task automatic test_back_to_back();
      rsp_rec_t e, a;
      for (int i = 0; i < 3; i++) push(32'hD000_0000 + 32'(i));
      rd(4'h4, 4'd1);
      #1;
      n_cmp++; if (rsp.gnt !== 1'b1) begin n_mis++; $display("FAIL b2b_gnt got %b expected 1", rsp.gnt); end
      rd(4'h0, 4'd2);
      rd(4'h4, 4'd3);
      wait_rsp();
      n_cmp++; if (act_q.size() != exp_q.size()) begin n_mis++; $display("FAIL b2b_rsp_count got %0d expected %0d", act_q.size(), exp_q.size()); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = (act_q.size() > 0) ? act_q.pop_front() : '0;
         n_cmp++;
         if (a !== e) begin n_mis++; $display("FAIL b2b_rsp got rdata=%h err=%b rid=%0d cyc=%0d expected rdata=%h err=%b rid=%0d cyc=%0d", a.rdata, a.err, a.rid, a.cyc, e.rdata, e.err, e.rid, e.cyc); end
      end
      act_q.delete();

      for (int i = 0; i < Depth + 1; i++) push(32'hE000_0000 + 32'(i));
      rd(4'h0, 4'd4);
      #1;
      n_cmp++; if (fifo_full !== 1'b1) begin n_mis++; $display("FAIL rst_pre_full got %b expected 1", fifo_full); end
      #1;
      rst_n = 1'b0;
      req.req = 1'b0;
      result_valid = 1'b0;
      e = exp_q.pop_back();
      mdl_q.delete();
      ovf_m = 1'b0; unf_m = 1'b0; thresh_m = 4'd8;
      repeat (2) @(negedge clk);
      n_cmp++; if (rsp.rvalid !== 1'b0) begin n_mis++; $display("FAIL rst_rvalid got %b expected 0", rsp.rvalid); end
      n_cmp++; if (fifo_full !== 1'b0) begin n_mis++; $display("FAIL rst_full got %b expected 0", fifo_full); end
      n_cmp++; if (act_q.size() != 0) begin n_mis++; $display("FAIL rst_dropped_rsp got %0d responses expected 0", act_q.size()); end
      act_q.delete();
      rst_n = 1'b1;
      rd(4'h4, 4'd5);
      rd(4'h0, 4'd6);
      wait_rsp();
      n_cmp++; if (act_q.size() != exp_q.size()) begin n_mis++; $display("FAIL rst_rsp_count got %0d expected %0d", act_q.size(), exp_q.size()); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = (act_q.size() > 0) ? act_q.pop_front() : '0;
         n_cmp++;
         if (a !== e) begin n_mis++; $display("FAIL rst_rsp got rdata=%h err=%b rid=%0d cyc=%0d expected rdata=%h err=%b rid=%0d cyc=%0d", a.rdata, a.err, a.rid, a.cyc, e.rdata, e.err, e.rid, e.cyc); end
      end
      act_q.delete();
   endtask

   initial begin
      test_reset();
      test_basic_and_underflow();
      test_overflow();
      test_err_flush();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "timeout");
   end

endmodule
